// File: rtl/hv_owt_rac_sched.sv
// hv_owt_rac_sched: schedules one HV one-wire transaction at a time.
// It takes a decoded rx frame and issues the register write, register read or
// ADC capture. It then waits out the bus turnaround gap and hands the response
// frame to the shared tx engine. Frames that arrive while busy are rejected
// and flagged.
//
// state     | meaning
// IDLE      | waiting for an rx frame
// WR        | one-cycle register write strobe
// RD        | one-cycle register read strobe
// RD_WAIT   | waiting for read data, bounded by the read timeout
// TURN      | bus turnaround gap before the response
// TX_REQ    | requesting the tx engine, response fields held
// TX_BUSY   | tx engine sending, waiting for done
module hv_owt_rac_sched #(
  parameter int unsigned      CMD_W     = 8,
  parameter int unsigned      DATA_W    = 8,
  parameter int unsigned      ADCD_W    = 10,
  parameter logic [CMD_W-2:0] ADC_ADDR  = 7'h1f,
  parameter int unsigned      TURN_CYC  = 16,
  parameter int unsigned      RD_TO_CYC = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_vld,
  input  logic [CMD_W-1:0]  i_rx_cmd,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_status,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  output logic [CMD_W-2:0]  o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  input  logic              i_reg_rdata_vld,
  input  logic [DATA_W-1:0] i_reg_rdata,
  input  logic [ADCD_W-1:0] i_adc_data,
  output logic              o_tx_req,
  input  logic              i_tx_ack,
  input  logic              i_tx_done,
  output logic [1:0]        o_tx_type,
  output logic [CMD_W-1:0]  o_tx_cmd,
  output logic [ADCD_W-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_drop,
  output logic              o_ovf,
  output logic              o_rd_timeout
);

  localparam int unsigned      MAX_CYC  = (TURN_CYC > RD_TO_CYC) ? TURN_CYC : RD_TO_CYC;
  localparam int unsigned      CNT_W    = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] RD_TO_LD = CNT_W'(RD_TO_CYC - 1);
  localparam logic [1:0]       TYPE_RD  = 2'b00;
  localparam logic [1:0]       TYPE_WR  = 2'b01;
  localparam logic [1:0]       TYPE_ADC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_TURN,
    S_TX_REQ,
    S_TX_BUSY
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_type;
  logic [ADCD_W-1:0] r_payload;
  logic              r_drop;
  logic              r_ovf;
  logic              r_rd_timeout;

  logic w_idle;
  logic w_accept;
  logic w_cnt_tc;
  logic w_is_wr;
  logic w_is_adc;
  logic w_rd_expire;
  logic w_reg_wr;
  logic w_reg_rd;
  logic w_tx_req;

  assign w_idle      = (r_state == S_IDLE);
  assign w_accept    = w_idle && i_rx_vld && !i_rx_status;
  assign w_cnt_tc    = (r_cnt == '0);
  assign w_is_wr     = i_rx_cmd[CMD_W-1];
  assign w_is_adc    = !i_rx_cmd[CMD_W-1] && (i_rx_cmd[CMD_W-2:0] == ADC_ADDR);
  // Read data arriving on the last wait cycle still wins over the timeout.
  assign w_rd_expire = (r_state == S_RD_WAIT) && !i_reg_rdata_vld && w_cnt_tc;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next-state logic and Moore strobes.
  always_comb begin
    w_state_nx = r_state;
    w_reg_wr   = 1'b0;
    w_reg_rd   = 1'b0;
    w_tx_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_wr)       w_state_nx = S_WR;
          else if (w_is_adc) w_state_nx = S_TURN;
          else               w_state_nx = S_RD;
        end
      end
      S_WR: begin
        w_reg_wr   = 1'b1;
        w_state_nx = S_TURN;
      end
      S_RD: begin
        w_reg_rd   = 1'b1;
        w_state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_reg_rdata_vld) w_state_nx = S_TURN;
        else if (w_cnt_tc)   w_state_nx = S_IDLE;
      end
      S_TURN: begin
        if (w_cnt_tc) w_state_nx = S_TX_REQ;
      end
      S_TX_REQ: begin
        w_tx_req = 1'b1;
        if (i_tx_ack) w_state_nx = S_TX_BUSY;
      end
      S_TX_BUSY: begin
        if (i_tx_done) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Shared down-counter: loaded on entry to TURN or RD_WAIT, holds at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nx == S_TURN && r_state != S_TURN) begin
      r_cnt <= TURN_LD;
    end else if (w_state_nx == S_RD_WAIT && r_state != S_RD_WAIT) begin
      r_cnt <= RD_TO_LD;
    end else if (!w_cnt_tc) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Transaction fields: latched on accept, payload filled as the response forms.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd     <= '0;
      r_data    <= '0;
      r_type    <= TYPE_RD;
      r_payload <= '0;
    end else if (w_accept) begin
      r_cmd  <= i_rx_cmd;
      r_data <= i_rx_data;
      if (w_is_wr) begin
        r_type    <= TYPE_WR;
        r_payload <= ADCD_W'(i_rx_data);
      end else begin
        r_type    <= w_is_adc ? TYPE_ADC : TYPE_RD;
        r_payload <= '0;
      end
    end else if (r_state == S_RD_WAIT && i_reg_rdata_vld) begin
      r_payload <= ADCD_W'(i_reg_rdata);
    end else if (r_state == S_TURN && w_cnt_tc && r_type == TYPE_ADC) begin
      r_payload <= i_adc_data;
    end
  end

  // Registered event pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop       <= 1'b0;
      r_ovf        <= 1'b0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_drop       <= w_idle && i_rx_vld && i_rx_status;
      r_ovf        <= !w_idle && i_rx_vld;
      r_rd_timeout <= w_rd_expire;
    end
  end

  assign o_reg_wr     = w_reg_wr;
  assign o_reg_rd     = w_reg_rd;
  assign o_tx_req     = w_tx_req;
  assign o_reg_addr   = r_cmd[CMD_W-2:0];
  assign o_reg_wdata  = r_data;
  assign o_tx_type    = r_type;
  assign o_tx_cmd     = r_cmd;
  assign o_tx_data    = r_payload;
  assign o_busy       = !w_idle;
  assign o_drop       = r_drop;
  assign o_ovf        = r_ovf;
  assign o_rd_timeout = r_rd_timeout;

endmodule
